// File: rtl/noc_vc_pkg.sv
// Shared types and helpers for the VC plane scheduler and related NoC arbitration logic.
package noc_vc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DRAIN
  } sched_state_e;

  localparam int unsigned SLICE_MAX_BITS = 256;
  localparam int unsigned SLICE_IDX_W    = $clog2(SLICE_MAX_BITS);

  typedef logic [SLICE_MAX_BITS-1:0] slice_vec_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OR-reduce the width-bit slice belonging to one plane of a packed per-plane vector.
  function automatic logic slice_any(input slice_vec_t vec, input int unsigned plane,
                                     input int unsigned width);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < width; i++) begin
      r = r | vec[SLICE_IDX_W'(plane * width + i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_rr_picker.sv
// Round-robin picker: first requester after the pointer, pointer itself checked last.
module vc_rr_picker
  import noc_vc_pkg::*;
#(
  parameter int unsigned VC = 4,
  localparam int unsigned IDX_W = idx_width(VC)
) (
  input  logic [VC-1:0]    req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] next_o,
  output logic             found_o
);

  int unsigned idx;

  always_comb begin
    next_o  = ptr_i;
    found_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= VC; k++) begin
      idx = (32'(ptr_i) + k) % VC;
      if (!found_o && req_i[IDX_W'(idx)]) begin
        found_o = 1'b1;
        next_o  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vc_plane_scheduler.sv
// Selects the VC plane driving the switch: round-robin with a cycle quantum, never
// leaving a plane that holds a reservation or is accepting a flit this cycle.
module vc_plane_scheduler
  import noc_vc_pkg::*;
#(
  parameter int unsigned VC            = 4,
  parameter int unsigned INPUTS        = 4,
  parameter int unsigned OUTPUTS       = 4,
  parameter int unsigned QUANTUM       = 8,
  parameter int unsigned COUNTER_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VC*OUTPUTS-1:0]   valid_out_portVC,
  input  logic [VC*INPUTS-1:0]    PortReservedVC,
  input  logic [INPUTS-1:0]       ready_in_switch,
  output logic [VC:0]             VCPlaneSelector,
  output logic [VC-1:0]           plane_active,
  output logic                    plane_switch
);

  localparam int unsigned IDX_W = idx_width(VC);
  localparam int unsigned SEL_W = VC + 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(QUANTUM - 1);

  sched_state_e             state_q, state_d;
  logic [IDX_W-1:0]         sel_q, sel_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     sw_q, sw_d;

  logic [VC-1:0]      req;
  logic [VC-1:0]      lock;
  logic [OUTPUTS-1:0] cur_valid;
  logic               fire;
  logic               can_leave;
  logic               at_decision;
  logic               found;
  logic [IDX_W-1:0]   next_idx;
  logic               decide;

  always_comb begin
    req       = '0;
    lock      = '0;
    cur_valid = '0;
    for (int unsigned v = 0; v < VC; v++) begin
      req[v]  = slice_any(slice_vec_t'(valid_out_portVC), v, OUTPUTS);
      lock[v] = slice_any(slice_vec_t'(PortReservedVC), v, INPUTS);
      if (IDX_W'(v) == sel_q) begin
        cur_valid = valid_out_portVC[v*OUTPUTS +: OUTPUTS];
      end
    end
  end

  // A head flit accepted now only reserves next cycle, so fire also pins the plane.
  assign fire        = |(cur_valid & ready_in_switch);
  assign can_leave   = !lock[sel_q] && !fire;
  assign at_decision = (cnt_q == CNT_LAST) || (!req[sel_q] && !lock[sel_q]);

  vc_rr_picker #(
    .VC (VC)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (sel_q),
    .next_o  (next_idx),
    .found_o (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sw_d    = 1'b0;
    decide  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          sel_d   = next_idx;
          state_d = SERVE;
          sw_d    = (next_idx != sel_q);
        end
      end
      SERVE: begin
        if (at_decision) begin
          if (can_leave) decide = 1'b1;
          else           state_d = DRAIN;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (can_leave) decide = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Shared decision-point rules for SERVE and DRAIN.
    if (decide) begin
      cnt_d   = '0;
      state_d = found ? SERVE : IDLE;
      if (found && (next_idx != sel_q)) begin
        sel_d = next_idx;
        sw_d  = 1'b1;
      end
    end
  end

  always_comb begin
    VCPlaneSelector     = SEL_W'(sel_q);
    plane_active        = '0;
    plane_active[sel_q] = 1'b1;
    plane_switch        = sw_q;
  end

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Directed self-checking bench for vc_plane_scheduler (VC=4, QUANTUM=8).
module tb_vc_plane_scheduler;

  localparam int unsigned VC      = 4;
  localparam int unsigned INPUTS  = 4;
  localparam int unsigned OUTPUTS = 4;
  localparam int unsigned QUANTUM = 8;

  localparam logic [15:0] PL0 = 16'h0001;
  localparam logic [15:0] PL1 = 16'h0010;
  localparam logic [15:0] PL2 = 16'h0100;
  localparam logic [15:0] PL3 = 16'h1000;

  logic                  clk;
  logic                  rst;
  logic [VC*OUTPUTS-1:0] valid_out_portVC;
  logic [VC*INPUTS-1:0]  PortReservedVC;
  logic [INPUTS-1:0]     ready_in_switch;
  logic [VC:0]           VCPlaneSelector;
  logic [VC-1:0]         plane_active;
  logic                  plane_switch;

  int n_vec;
  int n_err;

  vc_plane_scheduler #(
    .VC            (VC),
    .INPUTS        (INPUTS),
    .OUTPUTS       (OUTPUTS),
    .QUANTUM       (QUANTUM),
    .COUNTER_WIDTH (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_out_portVC (valid_out_portVC),
    .PortReservedVC   (PortReservedVC),
    .ready_in_switch  (ready_in_switch),
    .VCPlaneSelector  (VCPlaneSelector),
    .plane_active     (plane_active),
    .plane_switch     (plane_switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int exp_sel, input bit exp_sw);
    chk({tag, ".sel"}, 32'(VCPlaneSelector), 32'(exp_sel));
    chk({tag, ".active"}, 32'(plane_active), 32'(1) << exp_sel);
    chk({tag, ".switch"}, 32'(plane_switch), 32'(exp_sw));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    valid_out_portVC = '0;
    PortReservedVC   = '0;
    ready_in_switch  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_vec            = 0;
    n_err            = 0;
    rst              = 1'b1;
    valid_out_portVC = '0;
    PortReservedVC   = '0;
    ready_in_switch  = '0;
    #2;

    // Reset then idle
    do_reset();
    expect_out("reset", 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("idle", 0, 1'b0);
    end

    // Single plane 2, continuously firing
    do_reset();
    valid_out_portVC = PL2;
    ready_in_switch  = 4'hF;
    tick();
    expect_out("single.grant", 2, 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick();
      expect_out("single.hold", 2, 1'b0);
    end

    // Rotation: all planes request, nothing fires
    do_reset();
    valid_out_portVC = PL0 | PL1 | PL2 | PL3;
    ready_in_switch  = 4'h0;
    for (int k = 0; k < 40; k++) begin
      tick();
      expect_out("rotate", (1 + k / 8) % 4, (k % 8) == 0);
    end

    // Packet hold: plane 1 reserved past quantum expiry, plane 3 waiting
    do_reset();
    valid_out_portVC = PL1 | PL3;
    ready_in_switch  = 4'h0;
    for (int k = 0; k <= 21; k++) begin
      PortReservedVC = (k >= 3 && k <= 20) ? PL1 : 16'h0;
      tick();
      if (k <= 20) expect_out("hold.drain", 1, k == 0);
      else         expect_out("hold.release", 3, 1'b1);
    end

    // Fire-edge race on plane 0 at quantum expiry
    do_reset();
    valid_out_portVC = PL0;
    tick();
    expect_out("race.grant0", 0, 1'b0);
    valid_out_portVC = PL0 | PL1;
    for (int k = 1; k <= 15; k++) begin
      ready_in_switch = (k == 8) ? 4'h1 : 4'h0;
      PortReservedVC  = (k >= 9 && k <= 14) ? PL0 : 16'h0;
      tick();
      if (k < 15) expect_out("race.hold", 0, 1'b0);
      else        expect_out("race.switch", 1, 1'b1);
    end

    // Mid-packet reset while draining plane 2
    do_reset();
    valid_out_portVC = PL2 | PL3;
    ready_in_switch  = 4'hF;
    for (int k = 0; k < 12; k++) begin
      tick();
      expect_out("mrst.drain", 2, k == 0);
    end
    rst = 1'b1;
    tick();
    expect_out("mrst.reset", 0, 1'b0);
    rst              = 1'b0;
    valid_out_portVC = PL3;
    ready_in_switch  = 4'h0;
    tick();
    expect_out("mrst.resume", 3, 1'b1);
    tick();
    expect_out("mrst.stay", 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vc_plane_scheduler.md
# vc_plane_scheduler

Picks which virtual-channel plane drives the router switch each cycle and produces `VCPlaneSelector` for the VC multiplexer directly downstream. Planes are served round-robin with a cycle quantum. A plane is never switched away from while it owns a packet in flight, so flits of different packets never interleave on one switch port. The selector is a registered output, so the downstream mux sees a stable plane for whole cycles.

## Interface
Parameters:
- `VC`, 4, number of VC planes (≥2)
- `INPUTS`, 4, switch input ports; must equal `OUTPUTS`
- `OUTPUTS`, 4, per-plane port slice width
- `QUANTUM`, 8, cycles a plane is served before rotation is considered (≥1)
- `COUNTER_WIDTH`, 8, quantum counter width; 2^COUNTER_WIDTH > QUANTUM

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `valid_out_portVC`  in  VC*OUTPUTS  per-plane, per-port flit valid; plane v is bits `[v*OUTPUTS +: OUTPUTS]`
- `PortReservedVC`  in  VC*INPUTS  per-plane port reservation; plane v is bits `[v*INPUTS +: INPUTS]`
- `ready_in_switch`  in  INPUTS  switch ready, applies to the currently selected plane
- `VCPlaneSelector`  out  VC+1  registered index of the active plane; reset 0
- `plane_active`  out  VC  one-hot of `VCPlaneSelector`; reset 1 (plane 0)
- `plane_switch`  out  1  one-cycle pulse in the first cycle a new plane is selected; reset 0

## Operation
- Per-plane signals:
  - `req[v]` = OR of plane v's valid slice.
  - `lock[v]` = OR of plane v's reserved slice.
  - `fire` = OR(valid slice of the current plane AND `ready_in_switch`).
- `can_leave` = !lock[cur] && !fire. A head flit accepted this cycle only shows up as a reservation next cycle, so a switch in that cycle is forbidden.
- `next` = first v with req[v], searching cur+1, cur+2, … wrapping modulo VC, with cur itself checked last.
- State IDLE (reset state):
  - No req: hold the selector and counter at 0.
  - Any req: load `next`, counter←0, go to SERVE.
  - Pulse `plane_switch` only if `next` ≠ cur.
- State SERVE: counter increments every cycle and saturates at QUANTUM-1. A decision point is reached when counter==QUANTUM-1, or when !req[cur] && !lock[cur].
  - At a decision point with can_leave:
    - Another plane requests: load `next`, counter←0, pulse `plane_switch`, stay in SERVE.
    - Only cur requests: counter←0, no pulse.
    - No req anywhere: go to IDLE, selector held.
  - At a decision point with !can_leave: go to DRAIN, selector held.
- State DRAIN: selector held and counter frozen. On the first cycle with can_leave, apply the SERVE decision-point rules.
- Rotation pointer is the current selector; there is no separate priority register.
- Reset mid-packet is accepted: state→IDLE, selector→0, counter→0, `plane_switch`→0. Upstream buffers reset in the same cycle.
- `VCPlaneSelector` values ≥ VC are never produced.

## Timing
- All decisions use current-cycle inputs. The new selector is visible the cycle after the decision edge, so latency from request to grant is 1 cycle.
- `plane_switch` is high for exactly the first cycle the new value is driven.
- Minimum dwell on a plane is 1 cycle when it empties unlocked. Maximum dwell is QUANTUM cycles plus the drain of the packet in flight.
- Simultaneous quantum expiry and a `fire` on cur goes to DRAIN, not a switch.
- Simultaneous requests from all planes give strict rotation 0→1→2→3→0.

## Structure
- Shared package `noc_vc_pkg`:
  - state enum {IDLE, SERVE, DRAIN}
  - `$clog2`-based width constants
  - plane-slice helper function
- Sub-module `vc_rr_picker`: combinational, takes a VC-bit request mask and a pointer, returns `next` as index plus found flag. Reusable by the switch allocator.
- Top holds the state register, counter, selector register and pulse logic.

## Test plan
- Reset then idle: rst high 2 cycles, no valids → selector 0, plane_active 0001, plane_switch 0 for 20 cycles.
- Single plane: plane 2 valid continuously, ready high, no reservations → selector 2 one cycle after valid, one plane_switch pulse, no further pulses over 50 cycles.
- Rotation: all planes valid, no reservations, QUANTUM=8 → selector sequence 1,2,3,0,… changing every 8 cycles, pulse on each change.
- Packet hold: plane 1 reserved from cycle 3 to 20 with plane 3 requesting, QUANTUM=8 → DRAIN entered at expiry; selector moves to 3 exactly one cycle after reservation drops, no flit of plane 3 before then.
- Fire-edge race: plane 0 head flit fires in the same cycle as quantum expiry, reservation rises next cycle → no switch; switch occurs only after that reservation clears.
- Mid-packet reset: assert rst while in DRAIN on plane 2 → next cycle selector 0, state IDLE; normal arbitration resumes after rst drops.
